// File: rtl/tt_um_jimktrains_vslc_pkg.sv
// Shared definitions for the vslc timer/capture peripheral set.
// Phase state encodings and default counter width.
package tt_um_jimktrains_vslc_pkg;

    localparam int unsigned VslcWidth = 10;
    localparam logic [VslcWidth-1:0] VslcCounterMax = {VslcWidth{1'b1}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } vslc_state_e;

endpackage

// File: rtl/tt_um_jimktrains_vslc_edge_sync.sv
// Input sampling and edge detection for vslc capture.
// Define VSLC_CAPTURE_SYNC_EN for a 2-flop synchronizer ahead of s (adds one cycle of latency).
module tt_um_jimktrains_vslc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic s_d;

    // These flops run regardless of capture_enabled, so s_d always tracks s and
    // enabling with the input already high cannot produce a false edge.
`ifdef VSLC_CAPTURE_SYNC_EN
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            s    <= 1'b0;
            s_d  <= 1'b0;
        end else begin
            meta <= din;
            s    <= meta;
            s_d  <= s;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s   <= din;
            s_d <= s;
        end
    end
`endif

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/tt_um_jimktrains_vslc_capture.sv
// Input capture for the vslc timer: reports high/low phase lengths (stored as length - 1).
// Define VSLC_CAPTURE_SYNC_EN to build in a 2-flop synchronizer on capture_input.
module tt_um_jimktrains_vslc_capture
    import tt_um_jimktrains_vslc_pkg::*;
#(
    parameter int unsigned WIDTH = VslcWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_enabled,
    input  logic             capture_input,
    output logic [WIDTH-1:0] capture_high_o,
    output logic [WIDTH-1:0] capture_low_o,
    output logic             capture_valid,
    output logic             capture_overflow,
    output logic [WIDTH-1:0] capture_counter_o
);

    localparam logic [WIDTH-1:0] CntMax = {WIDTH{1'b1}};

    logic             s;
    logic             rise;
    logic             fall;
    vslc_state_e      state;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] high_tmp;
    logic             have_high;
    logic             ovf_tmp;

    tt_um_jimktrains_vslc_edge_sync u_edge_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (capture_input),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            counter          <= '0;
            high_tmp         <= '0;
            have_high        <= 1'b0;
            ovf_tmp          <= 1'b0;
            capture_high_o   <= '0;
            capture_low_o    <= '0;
            capture_valid    <= 1'b0;
            capture_overflow <= 1'b0;
        end else if (!capture_enabled) begin
            state            <= StIdle;
            counter          <= '0;
            high_tmp         <= '0;
            have_high        <= 1'b0;
            ovf_tmp          <= 1'b0;
            capture_high_o   <= '0;
            capture_low_o    <= '0;
            capture_valid    <= 1'b0;
            capture_overflow <= 1'b0;
        end else begin
            capture_valid <= 1'b0;
            case (state)
                StIdle: begin
                    // The phase in progress at start-up is partial; just sync to it.
                    counter <= '0;
                    if (rise || fall) begin
                        state <= s ? StHigh : StLow;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        high_tmp  <= counter;
                        have_high <= 1'b1;
                        counter   <= '0;
                        state     <= StLow;
                    end else if (counter == CntMax) begin
                        ovf_tmp <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                StLow: begin
                    if (rise) begin
                        if (have_high) begin
                            capture_high_o   <= high_tmp;
                            capture_low_o    <= counter;
                            capture_overflow <= ovf_tmp;
                            capture_valid    <= 1'b1;
                        end
                        ovf_tmp <= 1'b0;
                        counter <= '0;
                        state   <= StHigh;
                    end else if (counter == CntMax) begin
                        ovf_tmp <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    counter <= '0;
                end
            endcase
        end
    end

    assign capture_counter_o = counter;

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_capture.sv
// Scoreboard bench for vslc capture: directed waveforms push expected pairs,
// a negedge monitor pops and compares on every capture_valid strobe.
module tb_tt_um_jimktrains_vslc_capture;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         capture_enabled;
    logic         capture_input;
    logic [W-1:0] capture_high_o;
    logic [W-1:0] capture_low_o;
    logic         capture_valid;
    logic         capture_overflow;
    logic [W-1:0] capture_counter_o;

    typedef struct {
        int high;
        int low;
        int ovf;
        int gap;  // expected cycles since previous strobe, 0 = don't care
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    logic prev_valid = 1'b0;

    tt_um_jimktrains_vslc_capture #(
        .WIDTH(W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .capture_enabled  (capture_enabled),
        .capture_input    (capture_input),
        .capture_high_o   (capture_high_o),
        .capture_low_o    (capture_low_o),
        .capture_valid    (capture_valid),
        .capture_overflow (capture_overflow),
        .capture_counter_o(capture_counter_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void expect_pair(input int h, input int l, input int o, input int g);
        exp_t e;
        e.high = h;
        e.low  = l;
        e.ovf  = o;
        e.gap  = g;
        exp_q.push_back(e);
    endfunction

    // Hold capture_input at lvl for n clock cycles, starting on a negedge.
    task automatic phase(input logic lvl, input int n);
        capture_input = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_high"}, int'(capture_high_o), 0);
        check({tag, "_low"}, int'(capture_low_o), 0);
        check({tag, "_valid"}, int'(capture_valid), 0);
        check({tag, "_ovf"}, int'(capture_overflow), 0);
        check({tag, "_counter"}, int'(capture_counter_o), 0);
    endtask

    // Monitor: every strobe must match the oldest expected pair.
    always @(negedge clk) begin
        if (capture_valid) begin
            check("valid_one_cycle", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got high=%0d low=%0d ovf=%0d, wanted no strobe",
                         capture_high_o, capture_low_o, capture_overflow);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pair_high", int'(capture_high_o), e.high);
                check("pair_low", int'(capture_low_o), e.low);
                check("pair_ovf", int'(capture_overflow), e.ovf);
                if (e.gap != 0) check("strobe_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
        end
        prev_valid = capture_valid;
    end

    initial begin
        rst_n           = 1'b0;
        capture_enabled = 1'b0;
        capture_input   = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n           = 1'b1;
        capture_enabled = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback-style waveform: high 4, low 6 -> high=3, low=5 every 10 cycles.
        phase(1'b1, 4);
        phase(1'b0, 6);
        for (int i = 0; i < 4; i++) begin
            expect_pair(3, 5, 0, (i == 0) ? 0 : 10);
            phase(1'b1, 4);
            phase(1'b0, 6);
        end

        // 1-cycle high / 1-cycle low -> 0/0 every 2 cycles.
        expect_pair(3, 5, 0, 10);
        phase(1'b1, 1);
        phase(1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            expect_pair(0, 0, 0, 2);
            phase(1'b1, 1);
            phase(1'b0, 1);
        end

        // Saturating high phase: 1500 high, 4 low.
        expect_pair(0, 0, 0, 2);
        phase(1'b1, 1200);
        check("stuck_counter_sat", int'(capture_counter_o), 1023);
        check("stuck_hold_high", int'(capture_high_o), 0);
        check("stuck_no_valid", int'(capture_valid), 0);
        phase(1'b1, 300);
        phase(1'b0, 4);
        expect_pair(1023, 3, 1, 0);
        phase(1'b1, 3);
        phase(1'b0, 5);
        expect_pair(2, 4, 0, 8);
        phase(1'b1, 2);
        phase(1'b0, 3);

        // Disable during LOW with a high already captured: everything clears.
        capture_enabled = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("disable");
        capture_enabled = 1'b1;
        phase(1'b0, 2);
        phase(1'b1, 5);
        phase(1'b0, 7);
        expect_pair(4, 6, 0, 0);
        phase(1'b1, 3);
        phase(1'b0, 2);

        // Enable while the input is already high: no false rise.
        capture_enabled = 1'b0;
        phase(1'b1, 4);
        capture_enabled = 1'b1;
        phase(1'b1, 3);
        phase(1'b0, 4);
        phase(1'b1, 6);
        phase(1'b0, 2);
        expect_pair(5, 1, 0, 0);
        phase(1'b1, 2);
        phase(1'b0, 1);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-phase while outputs hold a non-zero pair.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_high", int'(capture_high_o), 0);
        check("async_rst_low", int'(capture_low_o), 0);
        check("async_rst_counter", int'(capture_counter_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        phase(1'b1, 4);
        phase(1'b0, 3);
        expect_pair(3, 2, 0, 0);
        phase(1'b1, 2);
        phase(1'b0, 2);
        repeat (4) @(negedge clk);

        check("all_strobes_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
